mcpu_alu_arbiter: RTL and testbench
===================================

// Module: mcpu_alu_arbiter
// PURPOSE
//  Shares one MCPU_Alu instance between NUM_REQ requesters (fetch/decode/exec/debug ports).
//  Picks one pending request round-robin and latches its opcode/operands into the ALU.
//  Returns the result with the requester id over a valid/ready response channel.
//  All outputs are registered. One operation is in flight at a time.
// PARAMETERS
//  CMD_SIZE   2  opcode width, passed to MCPU_Alu
//  WORD_SIZE  2  operand/result width, passed to MCPU_Alu
//  NUM_REQ    4  number of requesters, >=2
//  ID_W       2  requester-id width, equal to $clog2(NUM_REQ)
// PORTS
//  clk            in   1                   system clock, rising edge
//  rst_n          in   1                   async active-low reset
//  req_valid      in   NUM_REQ             per-requester request pending
//  req_ready      out  NUM_REQ             one-hot accept pulse
//  req_opcode     in   NUM_REQ*CMD_SIZE    requester i at [i*CMD_SIZE +: CMD_SIZE]
//  req_r1         in   NUM_REQ*WORD_SIZE   operand A, requester i at [i*WORD_SIZE +: WORD_SIZE]
//  req_r2         in   NUM_REQ*WORD_SIZE   operand B, same packing
//  resp_valid     out  1                   result available
//  resp_ready     in   1                   consumer takes result
//  resp_id        out  ID_W                index of the requester that owns the result
//  resp_data      out  WORD_SIZE           ALU out
//  resp_overflow  out  1                   ALU OVERFLOW for ADD only; 0 for other opcodes
//  busy           out  1                   high in any state except IDLE
// BEHAVIOUR
//  Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//   - Assertion forces state=IDLE, rr_ptr=0 and all outputs to 0, taking effect immediately.
//   - Any in-flight operation is dropped and no response is issued.
//  FSM: IDLE -> GRANT -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - If |req_valid, register grant = first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Then go to GRANT.
//  GRANT (1 cycle):
//   - req_ready[grant]=1; all other req_ready bits are 0.
//   - Latch opcode, r1 and r2 of the grant into the ALU input regs.
//  EXEC (1 cycle):
//   - Capture ALU out into resp_data.
//   - Capture OVERFLOW into resp_overflow, masked to 0 unless opcode==OP_ADD.
//   - Load resp_id=grant.
//  RESP:
//   - resp_valid=1. resp_id, resp_data and resp_overflow stay stable until resp_ready=1.
//   - On the handshake: resp_valid->0 next cycle, rr_ptr<=(grant+1) mod NUM_REQ, go to IDLE.
//  Latency: req_valid first seen in IDLE at cycle T -> req_ready at T+1 -> resp_valid at T+3.
//   - Minimum 4 cycles per operation.
//  Requester rule: hold valid and operands stable until req_ready. Deasserting earlier is a protocol violation.
//  No new request is accepted while busy. Requests arriving during GRANT/EXEC/RESP wait for IDLE.
//  rr_ptr wraps from NUM_REQ-1 to 0.
//   - Simultaneous requests are served in pointer order, so no requester starves.
//  Arithmetic is done entirely by MCPU_Alu: 00 AND, 01 OR, 10 XOR, 11 ADD (mod 2^WORD_SIZE).
// STRUCTURE
//  Shared include mcpu_alu_defs.vh holds:
//   - OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11;
//   - FSM encodings ST_IDLE/ST_GRANT/ST_EXEC/ST_RESP.
//  Sub-module mcpu_rr_arbiter (combinational): inputs req vector and rr_ptr; outputs grant index and any_req.
//  One MCPU_Alu instance, driven by the latched operand regs.
// TESTING
//  1 Single request: req0 ADD r1=11 r2=10 at T -> req_ready=0001 at T+1; resp_valid at T+3 with id=0, data=01, ovf=1.
//  2 Logic ops:
//    - req2 OR 01,10 -> data=11, ovf=0;
//    - req1 XOR 10,11 -> data=01;
//    - req3 AND 11,10 -> data=10, ovf=0 even if the ALU flags overflow.
//  3 All four valid with resp_ready=1 -> grants 0,1,2,3, then 0 again (wrap). No index is skipped or repeated early.
//  4 Fairness: after serving req2, req1 and req3 both valid -> req3 is granted before req1.
//  5 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0, busy=1.
//    - Then release -> IDLE next cycle, next grant one cycle later.
//  6 Reset mid-op: rst_n low during EXEC -> resp_valid, req_ready and busy are 0 at once.
//    - After release with req1 and req0 valid -> req0 granted first (rr_ptr=0).

Source files
------------

// File: rtl/mcpu_alu_arbiter_pkg.sv
// Shared opcode and FSM encodings for the MCPU ALU arbiter slice.
package mcpu_alu_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mcpu_alu.sv
// Combinational MCPU ALU: AND/OR/XOR/ADD with a carry-based overflow flag.
module MCPU_Alu
  import mcpu_alu_arbiter_pkg::*;
#(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2
) (
  input  logic [CMD_SIZE-1:0]  cmd,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 overflow
);

  logic [WORD_SIZE:0] sum;

  assign sum = {1'b0, r1} + {1'b0, r2};
  // The flag reflects the adder carry for every opcode; callers mask it.
  assign overflow = sum[WORD_SIZE];

  always_comb begin
    out = sum[WORD_SIZE-1:0];
    case (cmd)
      OP_AND:  out = r1 & r2;
      OP_OR:   out = r1 | r2;
      OP_XOR:  out = r1 ^ r2;
      default: out = sum[WORD_SIZE-1:0];
    endcase
  end

endmodule

// File: rtl/mcpu_rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping mod NUM_REQ.
module mcpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  assign any_req = |req;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/mcpu_alu_arbiter.sv
// Shares one MCPU_Alu between NUM_REQ requesters; one operation in flight at a time.
module mcpu_alu_arbiter
  import mcpu_alu_arbiter_pkg::*;
#(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*CMD_SIZE-1:0]   req_opcode,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_r1,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_r2,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [WORD_SIZE-1:0]          resp_data,
  output logic                          resp_overflow,
  output logic                          busy
);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr, grant, grant_c;
  logic                 any_req;
  logic [CMD_SIZE-1:0]  op_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] r1_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] r2_arr [NUM_REQ];
  logic [CMD_SIZE-1:0]  op_p1;
  logic [WORD_SIZE-1:0] r1_p1, r2_p1, alu_out;
  logic                 alu_ovf;

  function automatic logic mask_ovf(input logic [CMD_SIZE-1:0] op, input logic ovf);
    return (op == CMD_SIZE'(OP_ADD)) && ovf;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_opcode[i*CMD_SIZE +: CMD_SIZE];
      r1_arr[i] = req_r1[i*WORD_SIZE +: WORD_SIZE];
      r2_arr[i] = req_r2[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  mcpu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (grant_c),
    .any_req (any_req)
  );

  MCPU_Alu #(.CMD_SIZE(CMD_SIZE), .WORD_SIZE(WORD_SIZE)) u_alu (
    .cmd      (op_p1),
    .r1       (r1_p1),
    .r2       (r2_p1),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  // Stage p1: operands of the granted requester, captured on the accept cycle
  always_ff @(posedge clk) begin
    if (state == ST_GRANT) begin
      op_p1 <= op_arr[grant];
      r1_p1 <= r1_arr[grant];
      r2_p1 <= r2_arr[grant];
    end
  end

  // Stage p2: control FSM and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      req_ready     <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_data     <= '0;
      resp_overflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          grant     <= grant_c;
          req_ready <= NUM_REQ'(1) << grant_c;
          busy      <= 1'b1;
          state     <= ST_GRANT;
        end
        ST_GRANT: begin
          req_ready <= '0;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          resp_data     <= alu_out;
          resp_overflow <= mask_ovf(op_p1, alu_ovf);
          resp_id       <= grant;
          resp_valid    <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          rr_ptr     <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// Directed bench for mcpu_alu_arbiter: latency, ALU ops, round-robin order, backpressure, reset.
module tb_mcpu_alu_arbiter;
  import mcpu_alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [7:0] req_opcode = '0;
  logic [7:0] req_r1 = '0;
  logic [7:0] req_r2 = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [1:0] resp_id;
  logic [1:0] resp_data;
  logic       resp_overflow;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  mcpu_alu_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_r1        (req_r1),
    .req_r2        (req_r2),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    req_opcode[i*2 +: 2] = op;
    req_r1[i*2 +: 2]     = a;
    req_r2[i*2 +: 2]     = b;
    req_valid[i]         = 1'b1;
  endtask

  // Runs one full transaction for whichever requester is granted; returns observations only.
  task automatic serve(output int gid, output logic [1:0] rid, output logic [1:0] d,
                       output logic o, output bit ok);
    int n;
    ok = 1'b1; gid = -1; rid = '0; d = '0; o = 1'b0;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin step(); n++; end
    if (n >= 20) begin ok = 1'b0; return; end
    for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
    step();
    req_valid[gid] = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin step(); n++; end
    if (n >= 20) begin ok = 1'b0; return; end
    rid = resp_id; d = resp_data; o = resp_overflow;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_id, resp_data, resp_overflow, busy} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {req_ready, resp_valid, resp_id, resp_data, resp_overflow, busy});
    end
    step(); step();
    rst_n = 1'b1;
    n_tests++;
    if ({req_ready, resp_valid, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_held: got %b required 0", {req_ready, resp_valid, busy});
    end
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    issue(0, OP_ADD, 2'b11, 2'b10);
    step();
    n_tests++;
    if (req_ready !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: req_ready=%b busy=%b required 0001/1", req_ready, busy);
    end
    step();
    req_valid[0] = 1'b0;
    n_tests++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_exec: req_ready=%b resp_valid=%b required 0000/0", req_ready, resp_valid);
    end
    step();
    n_tests++;
    if ({resp_valid, resp_id, resp_data, resp_overflow} !== {1'b1, 2'd0, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL single_resp: v=%b id=%0d data=%b ovf=%b required 1/0/01/1", resp_valid, resp_id, resp_data, resp_overflow);
    end
    step();
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: resp_valid=%b busy=%b required 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_logic_ops();
    int gid; logic [1:0] rid, d; logic o; bit ok;
    logic [1:0] ops [3] = '{OP_OR, OP_XOR, OP_AND};
    int         ids [3] = '{2, 1, 3};
    logic [1:0] as  [3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] bs  [3] = '{2'b10, 2'b11, 2'b10};
    logic [1:0] exp [3] = '{2'b11, 2'b01, 2'b10};
    for (int t = 0; t < 3; t++) begin
      issue(ids[t], ops[t], as[t], bs[t]);
      serve(gid, rid, d, o, ok);
      n_tests++;
      if (!ok || gid != ids[t] || rid !== 2'(ids[t]) || d !== exp[t] || o !== 1'b0) begin
        n_fail++;
        $display("FAIL logic_op%0d: ok=%0d grant=%0d id=%0d data=%b ovf=%b required %0d/%0d/%b/0",
                 t, ok, gid, rid, d, o, ids[t], ids[t], exp[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid; logic [1:0] rid, d; logic o; bit ok;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) issue(i, OP_ADD, 2'(i), 2'b01);
    for (int t = 0; t < 5; t++) begin
      if (t == 3) issue(0, OP_ADD, 2'b00, 2'b01);
      serve(gid, rid, d, o, ok);
      n_tests++;
      if (!ok || gid != exp_id[t] || rid !== 2'(exp_id[t]) || d !== 2'(exp_id[t] + 1) ||
          o !== (exp_id[t] == 3)) begin
        n_fail++;
        $display("FAIL rr_order%0d: ok=%0d grant=%0d id=%0d data=%b ovf=%b required grant %0d",
                 t, ok, gid, rid, d, o, exp_id[t]);
      end
    end
  endtask

  task automatic test_fairness();
    int gid; logic [1:0] rid, d; logic o; bit ok;
    int exp_id [3] = '{2, 3, 1};
    issue(2, OP_XOR, 2'b01, 2'b11);
    serve(gid, rid, d, o, ok);
    n_tests++;
    if (!ok || gid != 2 || d !== 2'b10) begin
      n_fail++;
      $display("FAIL fair_first: ok=%0d grant=%0d data=%b required 2/10", ok, gid, d);
    end
    issue(1, OP_OR, 2'b00, 2'b01);
    issue(3, OP_AND, 2'b11, 2'b01);
    for (int t = 1; t < 3; t++) begin
      serve(gid, rid, d, o, ok);
      n_tests++;
      if (!ok || gid != exp_id[t] || rid !== 2'(exp_id[t]) || d !== 2'b01) begin
        n_fail++;
        $display("FAIL fair_order%0d: ok=%0d grant=%0d id=%0d data=%b required %0d/01", t, ok, gid, rid, d, exp_id[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int gid; logic [1:0] rid, d; logic o; bit ok;
    resp_ready = 1'b0;
    issue(0, OP_ADD, 2'b01, 2'b01);
    step();
    step();
    req_valid[0] = 1'b0;
    issue(1, OP_OR, 2'b10, 2'b01);
    step();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({resp_valid, resp_id, resp_data, resp_overflow, req_ready, busy} !== {1'b1, 2'd0, 2'b10, 1'b0, 4'b0000, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b id=%0d data=%b ovf=%b rdy=%b busy=%b required 1/0/10/0/0000/1",
                 c, resp_valid, resp_id, resp_data, resp_overflow, req_ready, busy);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_release: v=%b busy=%b rdy=%b required 0/0/0000", resp_valid, busy, req_ready);
    end
    step();
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_next_grant: req_ready=%b required 0010", req_ready);
    end
    serve(gid, rid, d, o, ok);
    n_tests++;
    if (!ok || gid != 1 || d !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_next_resp: ok=%0d grant=%0d data=%b required 1/11", ok, gid, d);
    end
  endtask

  task automatic test_reset_midop();
    int gid; logic [1:0] rid, d; logic o; bit ok;
    issue(0, OP_AND, 2'b11, 2'b11);
    serve(gid, rid, d, o, ok);
    n_tests++;
    if (!ok || gid != 0 || d !== 2'b11) begin
      n_fail++;
      $display("FAIL midop_setup: ok=%0d grant=%0d data=%b required 0/11", ok, gid, d);
    end
    issue(3, OP_ADD, 2'b01, 2'b01);
    step();
    step();
    req_valid[3] = 1'b0;
    issue(0, OP_XOR, 2'b11, 2'b01);
    issue(1, OP_OR, 2'b01, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({resp_valid, req_ready, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL midop_async: v=%b rdy=%b busy=%b required 0/0000/0", resp_valid, req_ready, busy);
    end
    step();
    rst_n = 1'b1;
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_dropped: resp_valid=%b required 0", resp_valid);
    end
    serve(gid, rid, d, o, ok);
    n_tests++;
    if (!ok || gid != 0 || rid !== 2'd0 || d !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_first: ok=%0d grant=%0d id=%0d data=%b required 0/0/10", ok, gid, rid, d);
    end
    serve(gid, rid, d, o, ok);
    n_tests++;
    if (!ok || gid != 1 || rid !== 2'd1 || d !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_second: ok=%0d grant=%0d id=%0d data=%b required 1/1/01", ok, gid, rid, d);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_logic_ops();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
